// File: rtl/aes_top.sv
// aes_top: iterative AES-128 encryption core, one round per clock.
//
// Ports
//   AES_clk            in   clock, rising edge
//   AES_rst_n          in   synchronous reset, active HIGH despite the name
//   AES_en             in   start request, sampled only while idle
//   AES_data_in[127:0] in   plaintext, bits [127:120] are byte 0
//   AES_key_in[127:0]  in   cipher key, same byte order
//   AES_data_out       out  ciphertext of the last completed block (registered)
//   AES_data_out_valid out  one-cycle pulse when AES_data_out updates
//
// Start edge loads data^key; the next ten edges each apply one round while
// the round key is expanded on the fly. Result appears 10 edges after start.

module aes_top (
    input  logic         AES_clk,
    input  logic         AES_rst_n,
    input  logic         AES_en,
    input  logic [127:0] AES_data_in,
    input  logic [127:0] AES_key_in,
    output logic [127:0] AES_data_out,
    output logic         AES_data_out_valid
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t       fsm_q;
    logic [3:0]   round_q;
    logic [127:0] st_q;
    logic [127:0] key_q;
    logic [127:0] data_out_q;
    logic         valid_q;

    logic [127:0] sr_d;
    logic [127:0] mc_d;
    logic [127:0] key_d;
    logic [127:0] st_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254, which maps 0 to 0)
    // followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        logic [7:0] b;
        p = gmul(x, x);
        r = p;
        for (int unsigned i = 1; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        return {sub_word(s[127:96]), sub_word(s[95:64]),
                sub_word(s[63:32]), sub_word(s[31:0])};
    endfunction

    // Byte k = 4*col + row sits at bits [127-8k -: 8].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_column(s[127:96]), mix_column(s[95:64]),
                mix_column(s[63:32]), mix_column(s[31:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
        n0 = k[127:96] ^ t;
        n1 = k[95:64]  ^ n0;
        n2 = k[63:32]  ^ n1;
        n3 = k[31:0]   ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // One round datapath; round_q is the round being applied, key_q holds
    // the previous round key so the next one is derived here.
    always_comb begin
        sr_d  = shift_rows(sub_bytes(st_q));
        mc_d  = mix_columns(sr_d);
        key_d = key_expand(key_q, rcon(round_q));
        st_d  = ((round_q == 4'd10) ? sr_d : mc_d) ^ key_d;
    end

    always_ff @(posedge AES_clk) begin
        if (AES_rst_n) begin
            fsm_q      <= IDLE;
            round_q    <= '0;
            st_q       <= '0;
            key_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (AES_en) begin
                        st_q    <= AES_data_in ^ AES_key_in;
                        key_q   <= AES_key_in;
                        round_q <= 4'd1;
                        fsm_q   <= BUSY;
                    end
                end
                BUSY: begin
                    st_q  <= st_d;
                    key_q <= key_d;
                    if (round_q == 4'd10) begin
                        data_out_q <= st_d;
                        valid_q    <= 1'b1;
                        round_q    <= '0;
                        fsm_q      <= IDLE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign AES_data_out       = data_out_q;
    assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes_top.sv
// tb_aes_top: self-checking bench for aes_top against a byte-array AES-128
// reference model with a full precomputed key schedule.

module tb_aes_top;

    logic         clk;
    logic         rst;
    logic         en;
    logic [127:0] din;
    logic [127:0] kin;
    logic [127:0] dout;
    logic         vld;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb [256];

    aes_top dut (
        .AES_clk           (clk),
        .AES_rst_n         (rst),
        .AES_en            (en),
        .AES_data_in       (din),
        .AES_key_in        (kin),
        .AES_data_out      (dout),
        .AES_data_out_valid(vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        while (y != 8'h00) begin
            if (y[0]) p = p ^ x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Brute-force inverse, then the affine map bit by bit.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] o;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                o[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            end
            sb[x] = o;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] a [4];
        logic [7:0] rc;
        logic [7:0] hold;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127 - 8*i -: 8];
            s[i] = pt[127 - 8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i - 4 + j];
            if (i % 16 == 0) begin
                hold = tmp[0];
                tmp[0] = sb[tmp[1]] ^ rc;
                tmp[1] = sb[tmp[2]];
                tmp[2] = sb[tmp[3]];
                tmp[3] = sb[hold];
                rc = mul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i + j] = w[i - 16 + j] ^ tmp[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c + row] = t[4*((c + row) % 4) + row];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int row = 0; row < 4; row++) a[row] = s[4*c + row];
                    for (int row = 0; row < 4; row++)
                        s[4*c + row] = mul(8'h02, a[row]) ^ mul(8'h03, a[(row + 1) % 4])
                                     ^ a[(row + 2) % 4] ^ a[(row + 3) % 4];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Present a block at a negedge, then wait for the valid pulse.
    // lat = number of edges after the start edge (-1 on timeout).
    task automatic start_and_wait(input logic [127:0] k, input logic [127:0] p,
                                  input bit scramble, input bit release_rst,
                                  output logic [127:0] ct, output int lat);
        @(negedge clk);
        if (release_rst) rst = 1'b0;
        kin = k;
        din = p;
        en  = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            en = 1'b0;
            if (scramble) begin
                din = rnd128();
                kin = rnd128();
            end
            @(posedge clk);
            #1;
            if (vld === 1'b1) begin
                lat = n;
                break;
            end
        end
        ct = dout;
    endtask

    task automatic test_reset();
        logic [127:0] ct;
        int lat;
        rst = 1'b1;
        en  = 1'b1;
        din = rnd128();
        kin = rnd128();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (dout !== 128'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h want 0", dout);
        end
        checks++;
        if (vld !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", vld);
        end
        // first start on the first edge after reset release
        start_and_wait(128'h000102030405060708090a0b0c0d0e0f,
                       128'h00112233445566778899aabbccddeeff, 1'b0, 1'b1, ct, lat);
        checks++;
        if (ct !== 128'h69c4e0d86a7b0430d8cdb78070b4c55a) begin
            errors++;
            $display("FAIL first_start_ct: got %h want 69c4e0d86a7b0430d8cdb78070b4c55a", ct);
        end
        checks++;
        if (lat !== 10) begin
            errors++;
            $display("FAIL first_start_latency: got %0d want 10", lat);
        end
    endtask

    task automatic test_vectors();
        logic [127:0] keys [3];
        logic [127:0] pts  [3];
        logic [127:0] exps [3];
        logic [127:0] ct;
        int lat;
        keys[0] = 128'h000102030405060708090a0b0c0d0e0f;
        pts[0]  = 128'h00112233445566778899aabbccddeeff;
        exps[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        keys[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        pts[1]  = 128'h3243f6a8885a308d313198a2e0370734;
        exps[1] = 128'h3925841d02dc09fbdc118597196a0b32;
        keys[2] = 128'h0;
        pts[2]  = 128'h0;
        exps[2] = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        for (int v = 0; v < 3; v++) begin
            start_and_wait(keys[v], pts[v], 1'b0, 1'b0, ct, lat);
            checks++;
            if (ct !== exps[v]) begin
                errors++;
                $display("FAIL vector%0d_ct: got %h want %h", v, ct, exps[v]);
            end
            checks++;
            if (lat !== 10) begin
                errors++;
                $display("FAIL vector%0d_latency: got %0d want 10", v, lat);
            end
            @(posedge clk);
            #1;
            checks++;
            if (vld !== 1'b0) begin
                errors++;
                $display("FAIL vector%0d_pulse_width: valid got %b want 0", v, vld);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] k, p, ct, exp_ct;
        int lat;
        for (int i = 0; i < 6; i++) begin
            k = rnd128();
            p = rnd128();
            exp_ct = aes_ref(k, p);
            start_and_wait(k, p, 1'b0, 1'b0, ct, lat);
            checks++;
            if (ct !== exp_ct || lat !== 10) begin
                errors++;
                $display("FAIL random%0d: got %h lat %0d want %h lat 10", i, ct, lat, exp_ct);
            end
        end
        // output must hold between completions
        @(negedge clk);
        en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (dout !== exp_ct || vld !== 1'b0) begin
            errors++;
            $display("FAIL hold: got %h valid %b want %h valid 0", dout, vld, exp_ct);
        end
    endtask

    task automatic test_scramble();
        logic [127:0] ct;
        int lat;
        start_and_wait(128'h2b7e151628aed2a6abf7158809cf4f3c,
                       128'h3243f6a8885a308d313198a2e0370734, 1'b1, 1'b0, ct, lat);
        checks++;
        if (ct !== 128'h3925841d02dc09fbdc118597196a0b32 || lat !== 10) begin
            errors++;
            $display("FAIL scramble: got %h lat %0d want 3925841d02dc09fbdc118597196a0b32 lat 10",
                     ct, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] ka, pa, kb, pb;
        int hit_n [4];
        logic [127:0] hit_v [4];
        int hits;
        ka = rnd128();
        pa = rnd128();
        kb = rnd128();
        pb = rnd128();
        hits = 0;
        @(negedge clk);
        en  = 1'b1;
        kin = ka;
        din = pa;
        @(posedge clk);
        for (int n = 1; n <= 26; n++) begin
            @(negedge clk);
            if (n == 1) begin
                kin = kb;
                din = pb;
            end
            if (n == 12) en = 1'b0;
            @(posedge clk);
            #1;
            if (vld === 1'b1 && hits < 4) begin
                hit_n[hits] = n;
                hit_v[hits] = dout;
                hits++;
            end
        end
        checks++;
        if (hits !== 2) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d want 2", hits);
        end else begin
            checks++;
            if (hit_n[0] !== 10 || hit_n[1] !== 21) begin
                errors++;
                $display("FAIL b2b_pulse_timing: got %0d,%0d want 10,21", hit_n[0], hit_n[1]);
            end
            checks++;
            if (hit_v[0] !== aes_ref(ka, pa)) begin
                errors++;
                $display("FAIL b2b_block0: got %h want %h", hit_v[0], aes_ref(ka, pa));
            end
            checks++;
            if (hit_v[1] !== aes_ref(kb, pb)) begin
                errors++;
                $display("FAIL b2b_block1: got %h want %h", hit_v[1], aes_ref(kb, pb));
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] k, p, ct;
        int lat;
        bit saw_valid;
        @(negedge clk);
        en  = 1'b1;
        kin = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        din = 128'h3243f6a8885a308d313198a2e0370734;
        @(posedge clk);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            en = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dout !== 128'h0 || vld !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got %h valid %b want 0 valid 0", dout, vld);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (vld !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid || dout !== 128'h0) begin
            errors++;
            $display("FAIL abort_no_result: saw_valid %b dout %h want 0 and 0", saw_valid, dout);
        end
        k = rnd128();
        p = rnd128();
        start_and_wait(k, p, 1'b0, 1'b0, ct, lat);
        checks++;
        if (ct !== aes_ref(k, p) || lat !== 10) begin
            errors++;
            $display("FAIL abort_restart: got %h lat %0d want %h lat 10", ct, lat, aes_ref(k, p));
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        din = '0;
        kin = '0;
        build_sbox();
        test_reset();
        test_vectors();
        test_random();
        test_scramble();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_top.md
AES_TOP -- requirements
Module: aes_top

Interface
REQ-001 AES_clk  input  1  single clock; all state updates on rising edge.
REQ-002 AES_rst_n  input  1  reset; synchronous, active-high: a 1 sampled at a rising edge resets the block, despite the _n suffix.
REQ-003 AES_en  input  1  start request; level-sampled, acted on only when idle.
REQ-004 AES_data_in  input  128  plaintext block; bits [127:120] are FIPS-197 byte 0, [7:0] are byte 15.
REQ-005 AES_key_in  input  128  AES-128 cipher key; same byte ordering as AES_data_in.
REQ-006 AES_data_out  output  128  ciphertext of the most recently completed encryption; same byte ordering.
REQ-007 AES_data_out_valid  output  1  one-cycle pulse marking a new AES_data_out value.
REQ-008 No parameters; widths are fixed.

Function
REQ-009 The block SHALL perform AES-128 encryption per FIPS-197: 10 rounds, column-major state (byte i goes to row i%4, column i/4), standard S-box, ShiftRows, MixColumns, AddRoundKey.
REQ-010 States: IDLE and BUSY; an internal round counter runs 1..10.
REQ-011 Start edge E0 occurs in IDLE with AES_en=1. At E0 the block SHALL load state = AES_data_in XOR AES_key_in, latch AES_key_in as round key 0, set round=1, and enter BUSY.
REQ-012 At each edge E1..E9 the block SHALL apply one full round (SubBytes, ShiftRows, MixColumns, AddRoundKey) and compute the next round key on the fly (RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1b,36).
REQ-013 At edge E10 the block SHALL apply the final round (no MixColumns), write the result to AES_data_out, set AES_data_out_valid=1, and return to IDLE.
REQ-014 Latency is 10 clock edges from start to valid. AES_data_out_valid SHALL be high for exactly the cycle after E10 and low at E11 unless another completion occurs.
REQ-015 In BUSY, AES_en, AES_data_in and AES_key_in SHALL be ignored; changing them mid-operation does not affect the result.
REQ-016 If AES_en is still high in IDLE after a completion, a new encryption SHALL start at E11 using the inputs present then. With AES_en held high, throughput is one block per 11 cycles.
REQ-017 AES_data_out SHALL hold its value between completions and update only at E10.
REQ-018 The S-box may be a table or computed logic. It must match FIPS-197 for all 256 inputs.
REQ-019 No combinational path from inputs to outputs; both outputs are registered.

Reset
REQ-020 While reset is asserted: state IDLE, round=0, AES_data_out=128'h0, AES_data_out_valid=0. AES_en is ignored on that edge.
REQ-021 Reset asserted during BUSY SHALL abort the operation: no valid pulse and no AES_data_out update for the aborted block.
REQ-022 The first start may occur at the first edge after reset deasserts with AES_en=1.

Verification
REQ-023 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> AES_data_out 69c4e0d86a7b0430d8cdb78070b4c55a, valid pulse 10 edges after start.
REQ-024 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-025 key 0, pt 0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
REQ-026 Run REQ-024 and change AES_data_in/AES_key_in every cycle while BUSY -> output unchanged, 3925841d...0b32.
REQ-027 Hold AES_en high across two blocks -> valid pulses 11 cycles apart, each exactly one cycle wide.
REQ-028 Assert reset at E5 of an encryption -> AES_data_out=0, valid stays 0, and the next start completes correctly.
